i2s_tx: RTL and testbench



---
 rtl/audio_pkg.sv | 13 +
 rtl/i2s_clk_gen.sv | 39 +++
 rtl/i2s_tx.sv | 110 +++++++++++
 tb/tb_i2s_tx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio types for the codec send/receive paths.
// Slot and frame geometry for 32-bit stereo I2S.
package audio_pkg;
  localparam int SLOT_W = 32;
  localparam int FRAME_BITS = 64;

  typedef logic [31:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;
endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit clock / word position generator.
// Emits a falling-tick strobe and a frame-load strobe at bit 63 -> 0.
module i2s_clk_gen
  import audio_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       bclk,
  output logic [5:0] bit_cnt,
  output logic       fall_tick,
  output logic       frame_load
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [5:0] LAST = 6'(FRAME_BITS - 1);

  logic [DW-1:0] div;
  logic          wrap;

  assign wrap       = (div == DIV_MAX);
  assign fall_tick  = wrap & bclk;
  assign frame_load = fall_tick & (bit_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      bclk    <= 1'b0;
      bit_cnt <= LAST;
    end else begin
      div <= wrap ? '0 : div + 1'b1;
      if (wrap)
        bclk <= ~bclk;
      if (fall_tick)
        bit_cnt <= bit_cnt + 6'd1;
    end
  end
endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter with a one-entry holding register.
// Define I2S_TX_UNDERRUN_ZERO_EN to send zeros on underrun (default: repeat last pair).
module i2s_tx
  import audio_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int SAMPLE_W = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_l,
  input  logic [31:0] in_r,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        underrun
);
  localparam int SH = SLOT_W - SAMPLE_W;
  localparam logic [5:0] SW = 6'(SAMPLE_W);

  logic [5:0] bit_cnt;
  logic       fall_tick;
  logic       frame_load;

  i2s_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk (
    .clk       (clk),
    .rst       (rst),
    .bclk      (bclk),
    .bit_cnt   (bit_cnt),
    .fall_tick (fall_tick),
    .frame_load(frame_load)
  );

  stereo_t    hold;
  stereo_t    fb;
  stereo_t    load_pair;
  logic       full;
  sample_t    sh_l;
  sample_t    sh_r;
  logic [5:0] nxt;
  logic [4:0] pos;
  logic       in_slot;
  logic       accept;

  assign lrclk    = bit_cnt[5];
  assign in_ready = ~full;
  assign accept   = in_valid & ~full;

  // Position the serializer moves to on this falling tick.
  assign nxt     = bit_cnt + 6'd1;
  assign pos     = nxt[4:0];
  assign in_slot = (pos != 5'd0) && ({1'b0, pos} <= SW);

`ifdef I2S_TX_UNDERRUN_ZERO_EN
  assign fb = '0;
`else
  stereo_t last;

  always_ff @(posedge clk) begin
    if (rst)
      last <= '0;
    else if (frame_load & full)
      last <= hold;
  end

  assign fb = last;
`endif

  assign load_pair = full ? hold : fb;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold     <= '0;
      full     <= 1'b0;
      sh_l     <= '0;
      sh_r     <= '0;
      sdata    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= frame_load & ~full;
      if (frame_load & full) begin
        full <= 1'b0;
      end else if (accept) begin
        full <= 1'b1;
        hold <= '{l: in_l, r: in_r};
      end
      // Left-align so the sample MSB sits at bit 31 of each shifter.
      if (frame_load) begin
        sh_l  <= load_pair.l << SH;
        sh_r  <= load_pair.r << SH;
        sdata <= 1'b0;
      end else if (fall_tick) begin
        sdata <= 1'b0;
        if (in_slot) begin
          if (nxt[5]) begin
            sdata <= sh_r[SLOT_W-1];
            sh_r  <= sh_r << 1;
          end else begin
            sdata <= sh_l[SLOT_W-1];
            sh_l  <= sh_l << 1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx at CLK_DIV=4, SAMPLE_W=24.
// Frame k is loaded at cycle 8+512k; bit p is sampled mid-bit at load+8p+4.
module tb_i2s_tx;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_l;
  logic [31:0] in_r;
  logic        in_valid;
  logic        in_ready;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        underrun;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  localparam logic [63:0] WS = {32'h0, 32'hFFFF_FFFF};

  i2s_tx #(
    .CLK_DIV (4),
    .SAMPLE_W(24)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_l    (in_l),
    .in_r    (in_r),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .bclk    (bclk),
    .lrclk   (lrclk),
    .sdata   (sdata),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic at_cyc(input int n);
    int g = 0;
    while (cyc != n) begin
      @(negedge clk);
      g++;
      if (g > 20000) begin
        $display("FAIL at_cyc timeout got %0d expected %0d", cyc, n);
        n_fail++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic read_frame(input int ld, output logic [63:0] d,
                            output logic [63:0] w);
    for (int p = 0; p < 64; p++) begin
      at_cyc(ld + 8 * p + 4);
      d[63-p] = sdata;
      w[63-p] = lrclk;
    end
  endtask

  function automatic logic [63:0] exp_frame(input logic [31:0] l,
                                            input logic [31:0] r);
    return {1'b0, l[23:0], 7'b0, 1'b0, r[23:0], 7'b0};
  endfunction

  localparam logic [31:0] AL = 32'h00A5F00F;
  localparam logic [31:0] AR = 32'h00800001;
  localparam logic [31:0] BL = 32'hFF123456;
  localparam logic [31:0] BR = 32'h00654321;
  localparam logic [31:0] CL = 32'h00000001;
  localparam logic [31:0] CR = 32'h00000002;

  logic [63:0] d0, w0, d1, w1;

  initial begin
    rst      = 1'b1;
    in_l     = '0;
    in_r     = '0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bclk", bclk, 0);
    chk("rst_lrclk", lrclk, 1);
    chk("rst_sdata", sdata, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_ur", underrun, 0);
    rst = 1'b0;

    at_cyc(4); chk("bclk_rise", bclk, 1);
    at_cyc(7); chk("ur_pre", underrun, 0);
    at_cyc(8);
    chk("ur_first", underrun, 1);
    chk("bclk_fall", bclk, 0);
    chk("lr_left", lrclk, 0);
    at_cyc(9);
    chk("ur_once", underrun, 0);
    chk("ready_idle", in_ready, 1);

    fork
      begin
        read_frame(8, d0, w0);
        chk("f0_data", d0, 64'h0);
        chk("f0_ws", w0, WS);
      end
      begin
        at_cyc(510);
        in_l = AL; in_r = AR; in_valid = 1'b1;
        at_cyc(511);
        chk("acc_a", in_ready, 0);
        in_l = BL; in_r = BR;
        at_cyc(515);
        chk("bp_hold", in_ready, 0);
        at_cyc(520);
        chk("ld_ready", in_ready, 1);
        chk("ld_no_ur", underrun, 0);
        at_cyc(521);
        chk("acc_b", in_ready, 0);
        in_valid = 1'b0;
      end
    join

    read_frame(520, d1, w1);
    chk("f1_data", d1, exp_frame(AL, AR));
    chk("f1_ws", w1, WS);

    read_frame(1032, d1, w1);
    chk("f2_data", d1, exp_frame(BL, BR));

    at_cyc(1541);
    in_l = CL; in_r = CR; in_valid = 1'b1;
    at_cyc(1542);
    chk("acc_c", in_ready, 0);
    in_valid = 1'b0;
    at_cyc(1544);
    chk("f3_no_ur", underrun, 0);
    read_frame(1544, d1, w1);
    chk("f3_data", d1, exp_frame(CL, CR));

    at_cyc(2056);
    chk("f4_ur", underrun, 1);
    chk("f4_ready", in_ready, 1);
    at_cyc(2057);
    chk("f4_ur_once", underrun, 0);
    read_frame(2056, d1, w1);
`ifdef I2S_TX_UNDERRUN_ZERO_EN
    chk("f4_data", d1, 64'h0);
`else
    chk("f4_data", d1, exp_frame(CL, CR));
`endif
    at_cyc(2568);
    chk("f5_ur", underrun, 1);

    at_cyc(2880);
    in_l = 32'h00FFFFFF; in_r = 32'h00FFFFFF; in_valid = 1'b1;
    at_cyc(2881);
    chk("acc_d", in_ready, 0);
    in_valid = 1'b0;
    at_cyc(2893);
    chk("mid_bclk", bclk, 1);
    chk("mid_lr", lrclk, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_bclk", bclk, 0);
    chk("mrst_lr", lrclk, 1);
    chk("mrst_sdata", sdata, 0);
    chk("mrst_ready", in_ready, 1);
    chk("mrst_ur", underrun, 0);
    @(negedge clk);
    rst = 1'b0;

    at_cyc(7); chk("r_ur_pre", underrun, 0);
    at_cyc(8); chk("r_ur_first", underrun, 1);
    read_frame(8, d1, w1);
    chk("r_f0_data", d1, 64'h0);
    chk("r_f0_ws", w1, WS);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
